// File: rtl/grn_node_lut_if.sv
// Stimulus/status bundle for one Boolean-network node: run control,
// regulator inputs, truth-table load port and the two bank outputs.
interface grn_node_lut_if #(
    parameter int N_IN  = 3,
    parameter int CNT_W = 16
);
    localparam int LW = 1 << N_IN;

    logic              reset_nos;
    logic              init_state;
    logic              start_s0;
    logic              start_s1;
    logic [N_IN-1:0]   in_s0;
    logic [N_IN-1:0]   in_s1;
    logic              lut_we;
    logic [LW-1:0]     lut_wdata;
    logic              s0;
    logic              s1;
    logic              chg_s0;
    logic              chg_s1;
    logic [CNT_W-1:0]  steps_s0;
    logic [CNT_W-1:0]  steps_s1;

    modport master (
        output reset_nos, init_state, start_s0, start_s1,
        output in_s0, in_s1, lut_we, lut_wdata,
        input  s0, s1, chg_s0, chg_s1, steps_s0, steps_s1
    );

    modport slave (
        input  reset_nos, init_state, start_s0, start_s1,
        input  in_s0, in_s1, lut_we, lut_wdata,
        output s0, s1, chg_s0, chg_s1, steps_s0, steps_s1
    );
endinterface

// File: rtl/grn_node_lut.sv
// Boolean-network node with slow (tortoise) and fast (hare) state banks
// driven by a runtime-loadable truth table, for Floyd cycle detection.
module grn_node_lut #(
    parameter int              N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0] INIT_LUT = '0,
    parameter int              SLOW_DIV = 2,
    parameter int              CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    grn_node_lut_if.slave bus
);
    localparam int LW = 1 << N_IN;
    localparam int PW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0] PH_RESET = (SLOW_DIV > 1) ? PW'(1) : '0;

    logic [LW-1:0]    lut;
    logic [PW-1:0]    phase;
    logic             s0_q;
    logic             s1_q;
    logic             chg0_q;
    logic             chg1_q;
    logic [CNT_W-1:0] n0_q;
    logic [CNT_W-1:0] n1_q;
    logic             f0;
    logic             f1;

    // Strobes see the table as it stood before any same-cycle write.
    assign f0 = lut[bus.in_s0];
    assign f1 = lut[bus.in_s1];

    always_ff @(posedge clk) begin
        if (rst)
            lut <= INIT_LUT;
        else if (bus.lut_we)
            lut <= bus.lut_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q   <= 1'b0;
            chg0_q <= 1'b0;
            n0_q   <= '0;
            phase  <= PH_RESET;
        end else if (bus.reset_nos) begin
            s0_q   <= bus.init_state;
            chg0_q <= 1'b0;
            n0_q   <= '0;
            phase  <= '0;
        end else begin
            chg0_q <= 1'b0;
            if (bus.start_s0) begin
                if (phase == '0) begin
                    s0_q   <= f0;
                    chg0_q <= (f0 != s0_q);
                    if (~&n0_q)
                        n0_q <= n0_q + CNT_W'(1);
                end
                phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            chg1_q <= 1'b0;
            n1_q   <= '0;
        end else if (bus.reset_nos) begin
            s1_q   <= bus.init_state;
            chg1_q <= 1'b0;
            n1_q   <= '0;
        end else begin
            chg1_q <= 1'b0;
            if (bus.start_s1) begin
                s1_q   <= f1;
                chg1_q <= (f1 != s1_q);
                if (~&n1_q)
                    n1_q <= n1_q + CNT_W'(1);
            end
        end
    end

    assign bus.s0       = s0_q;
    assign bus.s1       = s1_q;
    assign bus.chg_s0   = chg0_q;
    assign bus.chg_s1   = chg1_q;
    assign bus.steps_s0 = n0_q;
    assign bus.steps_s1 = n1_q;
endmodule

// File: tb/tb_grn_node_lut.sv
// Directed bench for grn_node_lut: XOR3 table, divide-by-2 slow bank,
// 3-bit step counters so saturation is reachable.
module tb_grn_node_lut;
    localparam int N_IN  = 3;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    grn_node_lut_if #(.N_IN(N_IN), .CNT_W(CNT_W)) bus ();

    grn_node_lut #(
        .N_IN    (N_IN),
        .INIT_LUT(8'h96),
        .SLOW_DIV(2),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        string    tag;
        logic     s0;
        logic     s1;
        logic     c0;
        logic     c1;
        logic [CNT_W-1:0] n0;
        logic [CNT_W-1:0] n1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input string fld,
                       input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic s0, input logic s1,
                        input logic c0, input logic c1,
                        input int n0, input int n1);
        exp_t e;
        e.tag = tag;
        e.s0  = s0;
        e.s1  = s1;
        e.c0  = c0;
        e.c1  = c1;
        e.n0  = CNT_W'(n0);
        e.n1  = CNT_W'(n1);
        exp_q.push_back(e);
    endtask

    // Advance one clock, then retire one expected record if any is queued.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "s0", 8'(bus.s0), 8'(e.s0));
            chk(e.tag, "s1", 8'(bus.s1), 8'(e.s1));
            chk(e.tag, "chg_s0", 8'(bus.chg_s0), 8'(e.c0));
            chk(e.tag, "chg_s1", 8'(bus.chg_s1), 8'(e.c1));
            chk(e.tag, "steps_s0", 8'(bus.steps_s0), 8'(e.n0));
            chk(e.tag, "steps_s1", 8'(bus.steps_s1), 8'(e.n1));
        end
    endtask

    initial begin
        bus.reset_nos  = 1'b0;
        bus.init_state = 1'b0;
        bus.start_s0   = 1'b0;
        bus.start_s1   = 1'b0;
        bus.in_s0      = '0;
        bus.in_s1      = '0;
        bus.lut_we     = 1'b0;
        bus.lut_wdata  = '0;

        push("reset", 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // First slow strobe after rst is skipped, second one updates.
        bus.in_s0    = 3'b001;
        bus.start_s0 = 1'b1;
        push("skip_first", 0, 0, 0, 0, 0, 0);
        tick();
        push("second_s0", 1, 0, 1, 0, 1, 0);
        tick();
        bus.start_s0 = 1'b0;
        push("idle_chg_clr", 1, 0, 0, 0, 1, 0);
        tick();

        // Run restart, with a start_s1 that must be ignored.
        bus.reset_nos  = 1'b1;
        bus.init_state = 1'b1;
        bus.start_s1   = 1'b1;
        push("restart", 1, 1, 0, 0, 0, 0);
        tick();
        bus.reset_nos = 1'b0;
        bus.start_s1  = 1'b0;

        // Divider: four pulses, updates on 1 and 3 only, no change.
        bus.start_s0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push($sformatf("div_p%0d", i), 1, 1, 0, 0, (i + 1) / 2, 0);
            tick();
        end
        bus.start_s0 = 1'b0;

        // Fast bank: XOR3(0,1,1)=0 flips s1 from 1.
        bus.in_s1    = 3'b011;
        bus.start_s1 = 1'b1;
        push("fast_upd", 1, 0, 0, 1, 2, 1);
        tick();
        bus.start_s1 = 1'b0;
        push("fast_chg_pulse", 1, 0, 0, 0, 2, 1);
        tick();

        // Table write collides with a strobe: old table wins this cycle.
        bus.lut_we    = 1'b1;
        bus.lut_wdata = 8'hFF;
        bus.in_s1     = 3'b000;
        bus.start_s1  = 1'b1;
        push("lut_old", 1, 0, 0, 0, 2, 2);
        tick();
        bus.lut_we = 1'b0;
        push("lut_new", 1, 1, 0, 1, 2, 3);
        tick();

        // Counter saturation at 7.
        for (int i = 1; i <= 10; i++) begin
            push($sformatf("sat_p%0d", i), 1, 1, 0, 0, 2,
                 (3 + i > 7) ? 7 : 3 + i);
            tick();
        end

        // Restart mid-run together with a fast strobe.
        bus.reset_nos  = 1'b1;
        bus.init_state = 1'b0;
        push("restart_mid", 0, 0, 0, 0, 0, 0);
        tick();
        bus.reset_nos = 1'b0;

        // Phase restarts at 0; both banks step in the same cycle.
        bus.start_s0 = 1'b1;
        bus.in_s0    = 3'b001;
        push("both_strobes", 1, 1, 1, 1, 1, 1);
        tick();
        bus.start_s0 = 1'b0;
        bus.start_s1 = 1'b0;
        push("final_idle", 1, 1, 0, 0, 1, 1);
        tick();

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
